// File: rtl/banked_reg_file.sv
// Register file with banked SP, memory-mapped STATUS/PC/PCLINK, masked lane writes and a
// single-level exception save/restore of status and PC.
module banked_reg_file #(
    parameter int unsigned         WIDTH        = 32,
    parameter int unsigned         NUM_REGS     = 16,
    parameter int unsigned         ALU_STATUS_W = 4,
    parameter logic [WIDTH-1:0]    RESET_PC     = '0,
    localparam int unsigned        SEL_W        = $clog2(NUM_REGS),
    localparam int unsigned        SW           = ALU_STATUS_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        rd_sel_a,
    output logic [WIDTH-1:0]        rd_data_a,
    input  logic [SEL_W-1:0]        rd_sel_b,
    output logic [WIDTH-1:0]        rd_data_b,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [1:0]              wr_mask,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    flags_en,
    input  logic [ALU_STATUS_W-1:0] flags_in,
    input  logic                    exc_take,
    input  logic [WIDTH-1:0]        exc_vector,
    input  logic                    exc_ret,
    output logic [SW-1:0]           status,
    output logic [WIDTH-1:0]        pc
);

    localparam int unsigned      NumGpr    = NUM_REGS - 5;
    localparam logic [SEL_W-1:0] IdxStatus = SEL_W'(NUM_REGS - 5);
    localparam logic [SEL_W-1:0] IdxSp     = SEL_W'(NUM_REGS - 4);
    localparam logic [SEL_W-1:0] IdxLr     = SEL_W'(NUM_REGS - 3);
    localparam logic [SEL_W-1:0] IdxPclink = SEL_W'(NUM_REGS - 2);
    localparam logic [SEL_W-1:0] IdxPc     = SEL_W'(NUM_REGS - 1);
    localparam logic             ModeSup   = 1'b0;
    localparam logic             ModeUsr   = 1'b1;
    // {alu_status = 0, imask = 1, mode = SUPERVISOR}
    localparam logic [SW-1:0]    StatusRst = SW'(2);

    logic [WIDTH-1:0] gpr_q [NumGpr];
    logic [WIDTH-1:0] gpr_d [NumGpr];
    logic [WIDTH-1:0] sp_sup_q, sp_sup_d;
    logic [WIDTH-1:0] sp_usr_q, sp_usr_d;
    logic [WIDTH-1:0] lr_q, lr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SW-1:0]    status_q, status_d;
    logic [SW-1:0]    saved_q, saved_d;

    logic [WIDTH-1:0] reg_view [NUM_REGS];
    logic [WIDTH-1:0] lane_m;
    logic [WIDTH-1:0] merged;
    logic             is_user;
    logic             ret_ok;
    logic             status_wr;
    int unsigned      lane_bits;

    assign is_user = (status_q[0] == ModeUsr);
    assign ret_ok  = exc_ret && !exc_take && !is_user;

    // Architectural view of every index; SP follows the current mode, PCLINK aliases PC.
    always_comb begin
        reg_view = '{default: '0};
        for (int i = 0; i < NumGpr; i++) begin
            reg_view[i] = gpr_q[i];
        end
        reg_view[IdxStatus] = {{(WIDTH - SW){1'b0}}, status_q};
        reg_view[IdxSp]     = is_user ? sp_usr_q : sp_sup_q;
        reg_view[IdxLr]     = lr_q;
        reg_view[IdxPclink] = pc_q;
        reg_view[IdxPc]     = pc_q;
    end

    assign rd_data_a = reg_view[rd_sel_a];
    assign rd_data_b = reg_view[rd_sel_b];
    assign status    = status_q;
    assign pc        = pc_q;

    // LS24 naturally covers the whole word when WIDTH <= 24.
    always_comb begin
        unique case (wr_mask)
            2'd0:    lane_bits = 8;
            2'd1:    lane_bits = 16;
            2'd2:    lane_bits = 24;
            default: lane_bits = WIDTH;
        endcase
        lane_m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_m[i] = (i < lane_bits);
        end
        merged = (reg_view[wr_sel] & ~lane_m) | (wr_data & lane_m);
    end

    always_comb begin
        gpr_d     = gpr_q;
        sp_sup_d  = sp_sup_q;
        sp_usr_d  = sp_usr_q;
        lr_d      = lr_q;
        pc_d      = pc_q;
        status_d  = status_q;
        saved_d   = saved_q;
        status_wr = wr_en && (wr_sel == IdxStatus);

        if (exc_take) begin
            saved_d     = status_q;
            status_d[1] = 1'b1;
            status_d[0] = ModeSup;
            lr_d        = pc_q;
            pc_d        = exc_vector;
        end else if (ret_ok) begin
            status_d = saved_q;
            pc_d     = lr_q;
        end else begin
            if (flags_en && !status_wr) begin
                status_d[SW-1:2] = flags_in;
            end
            if (wr_en) begin
                unique case (wr_sel)
                    IdxStatus: begin
                        if (is_user) begin
                            status_d = {merged[SW-1:2], status_q[1:0]};
                        end else begin
                            status_d = merged[SW-1:0];
                        end
                    end
                    IdxSp: begin
                        if (is_user) begin
                            sp_usr_d = merged;
                        end else begin
                            sp_sup_d = merged;
                        end
                    end
                    IdxLr: lr_d = merged;
                    IdxPclink: begin
                        lr_d = pc_q;
                        pc_d = merged;
                    end
                    IdxPc: pc_d = merged;
                    default: begin
                        for (int i = 0; i < NumGpr; i++) begin
                            if (wr_sel == SEL_W'(i)) begin
                                gpr_d[i] = merged;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpr_q    <= '{default: '0};
            sp_sup_q <= '0;
            sp_usr_q <= '0;
            lr_q     <= '0;
            pc_q     <= RESET_PC;
            status_q <= StatusRst;
            saved_q  <= StatusRst;
        end else begin
            gpr_q    <= gpr_d;
            sp_sup_q <= sp_sup_d;
            sp_usr_q <= sp_usr_d;
            lr_q     <= lr_d;
            pc_q     <= pc_d;
            status_q <= status_d;
            saved_q  <= saved_d;
        end
    end

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file: masked writes, SP banking, PCLINK, exceptions,
// USER-mode protection and asynchronous reset.
module tb_banked_reg_file;

    localparam int unsigned  WIDTH    = 32;
    localparam int unsigned  NUM_REGS = 16;
    localparam int unsigned  ASW      = 4;
    localparam int unsigned  SEL_W    = 4;
    localparam logic [31:0]  RST_PC   = 32'h0000_0F00;

    localparam logic [3:0] R0 = 4'd0, R1 = 4'd1, R2 = 4'd2, R3 = 4'd3, R4 = 4'd4;
    localparam logic [3:0] STAT = 4'd11, SP = 4'd12, LR = 4'd13, PCLINK = 4'd14, PCR = 4'd15;

    logic             clk = 1'b0;
    logic             rst;
    logic [SEL_W-1:0] rd_sel_a, rd_sel_b, wr_sel;
    logic [WIDTH-1:0] rd_data_a, rd_data_b, wr_data, exc_vector;
    logic             wr_en, flags_en, exc_take, exc_ret;
    logic [1:0]       wr_mask;
    logic [ASW-1:0]   flags_in;
    logic [ASW+1:0]   status;
    logic [WIDTH-1:0] pc;

    int n_vec  = 0;
    int n_fail = 0;

    banked_reg_file #(
        .WIDTH        (WIDTH),
        .NUM_REGS     (NUM_REGS),
        .ALU_STATUS_W (ASW),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_sel_a   (rd_sel_a),
        .rd_data_a  (rd_data_a),
        .rd_sel_b   (rd_sel_b),
        .rd_data_b  (rd_data_b),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .flags_en   (flags_en),
        .flags_in   (flags_in),
        .exc_take   (exc_take),
        .exc_vector (exc_vector),
        .exc_ret    (exc_ret),
        .status     (status),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [3:0] sel, input logic [1:0] mask, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_mask = mask;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        rd_sel_a = sel;
        #1;
        check(tag, rd_data_a, exp);
    endtask

    initial begin
        rst = 1'b1;
        rd_sel_a = '0; rd_sel_b = '0; wr_sel = '0; wr_data = '0; exc_vector = '0;
        wr_en = 1'b0; flags_en = 1'b0; exc_take = 1'b0; exc_ret = 1'b0;
        wr_mask = 2'd3; flags_in = '0;
        #3;
        check("rst_pc", pc, RST_PC);
        check("rst_status", 32'(status), 32'h02);
        read_a("rst_r0", R0, 32'h0);
        read_a("rst_sp", SP, 32'h0);
        step();
        rst = 1'b0;

        // Masked writes; the write cycle still reads the old value.
        do_wr(R1, 2'd3, 32'hAABB_CCDD);
        rd_sel_a = R1;
        wr_en = 1'b1; wr_sel = R1; wr_mask = 2'd1; wr_data = 32'h1122_3344;
        #1;
        check("ls16_during", rd_data_a, 32'hAABB_CCDD);
        step();
        wr_en = 1'b0;
        check("ls16_after", rd_data_a, 32'hAABB_3344);
        do_wr(R2, 2'd3, 32'hFFFF_FFFF);
        do_wr(R2, 2'd0, 32'h1234_5678);
        read_a("ls8", R2, 32'hFFFF_FF78);
        do_wr(R3, 2'd2, 32'h1234_5678);
        read_a("ls24", R3, 32'h0034_5678);

        // PCLINK
        do_wr(PCR, 2'd3, 32'h40);
        check("pc_write", pc, 32'h40);
        do_wr(PCLINK, 2'd3, 32'h80);
        check("pclink_pc", pc, 32'h80);
        read_a("pclink_lr", LR, 32'h40);
        rd_sel_b = PCLINK;
        #1;
        check("pclink_read", rd_data_b, 32'h80);

        // Flags, then STATUS write beating a same-cycle flag update
        flags_en = 1'b1; flags_in = 4'hA;
        step();
        flags_en = 1'b0;
        check("flags_upd", 32'(status), 32'h2A);
        flags_en = 1'b1; flags_in = 4'h3;
        do_wr(STAT, 2'd3, 32'h3C);
        flags_en = 1'b0;
        check("stat_wins", 32'(status), 32'h3C);

        // SP banking
        do_wr(SP, 2'd3, 32'h100);
        do_wr(STAT, 2'd3, 32'h01);
        check("to_user", 32'(status), 32'h01);
        do_wr(SP, 2'd3, 32'h200);
        read_a("sp_usr", SP, 32'h200);
        exc_take = 1'b1; exc_vector = 32'h8;
        step();
        exc_take = 1'b0;
        read_a("sp_sup", SP, 32'h100);
        check("take1_status", 32'(status), 32'h02);
        check("take1_pc", pc, 32'h8);
        exc_ret = 1'b1;
        step();
        exc_ret = 1'b0;
        check("ret1_status", 32'(status), 32'h01);
        check("ret1_pc", pc, 32'h80);
        read_a("sp_usr_again", SP, 32'h200);

        // Exception round trip with a suppressed same-cycle write and flag update
        flags_en = 1'b1; flags_in = 4'h5;
        step();
        flags_en = 1'b0;
        check("user_flags", 32'(status), 32'h15);
        do_wr(PCR, 2'd3, 32'h10);
        exc_take = 1'b1; exc_vector = 32'h8;
        flags_en = 1'b1; flags_in = 4'hF;
        wr_en = 1'b1; wr_sel = R0; wr_mask = 2'd3; wr_data = 32'hDEAD;
        step();
        exc_take = 1'b0; flags_en = 1'b0; wr_en = 1'b0;
        check("take2_status", 32'(status), 32'h16);
        check("take2_pc", pc, 32'h8);
        read_a("take2_lr", LR, 32'h10);
        read_a("take2_r0", R0, 32'h0);
        exc_ret = 1'b1;
        step();
        exc_ret = 1'b0;
        check("ret2_status", 32'(status), 32'h15);
        check("ret2_pc", pc, 32'h10);

        // USER protection of imask/mode and ignored exc_ret
        do_wr(STAT, 2'd3, 32'hFFFF_FFFF);
        check("user_stat", 32'(status), 32'h3D);
        exc_ret = 1'b1;
        step();
        exc_ret = 1'b0;
        check("user_ret_status", 32'(status), 32'h3D);
        check("user_ret_pc", pc, 32'h10);

        // Asynchronous reset between edges during a write
        wr_en = 1'b1; wr_sel = R4; wr_mask = 2'd3; wr_data = 32'h55;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, RST_PC);
        check("arst_status", 32'(status), 32'h02);
        read_a("arst_r1", R1, 32'h0);
        read_a("arst_lr", LR, 32'h0);
        step();
        wr_en = 1'b0;
        read_a("arst_r4", R4, 32'h0);
        rst = 1'b0;
        step();
        read_a("post_rst_r4", R4, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
